// File: rtl/clock_divider.sv
// clock_divider: programmable square-wave generator.
//
// Derives clk_out from clk at the rate given in hertz on freq. The half-period
// count half = max(1, floor(CLK_HZ / (2*freq))) is produced by a 32-step
// restoring shift-subtract divider, one step per clock. A new count is only
// applied at a toggle boundary, so rate changes never glitch clk_out.
//
// Parameters:
//   CLK_HZ   frequency of clk in Hz
// Ports:
//   clk      system clock, rising-edge active
//   reset    asynchronous, active-high reset
//   freq     requested output frequency in Hz (0 stops the output)
//   clk_out  divided clock, registered, 50 % duty
//   locked   (CLOCK_DIVIDER_LOCKED_EN only) high once the active count matches freq
//
// Build option: define CLOCK_DIVIDER_LOCKED_EN to add the locked output.

module clock_divider #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] freq,
`ifdef CLOCK_DIVIDER_LOCKED_EN
  output logic        locked,
`endif
  output logic        clk_out
);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} div_state_e;

  div_state_e  state_q, state_d;
  logic [26:0] freq_lat_q;
  logic [4:0]  iter_q;
  logic [31:0] quo_q;
  logic [27:0] rem_q;
  logic [31:0] half_act_q, half_act_d;
  logic [31:0] half_pend_q, half_pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        clk_out_q, clk_out_d;

  logic        busy, freq_change, stop, start;
  logic [27:0] divisor;
  logic [28:0] trial;
  logic [27:0] diff;
  logic        ge;
  logic [31:0] half_new;

  assign busy        = (state_q != StIdle);
  assign freq_change = !busy && (freq != freq_lat_q);
  assign stop        = freq_change && (freq == 27'd0);
  assign start       = freq_change && (freq != 27'd0);

  // Remainder always stays below divisor (< 2^28), so 28 bits hold it and the
  // low 28 bits of the subtraction are exact whenever ge is set.
  assign divisor  = {freq_lat_q, 1'b0};
  assign trial    = {rem_q, quo_q[31]};
  assign ge       = (trial >= {1'b0, divisor});
  assign diff     = trial[27:0] - divisor;
  assign half_new = (quo_q == 32'd0) ? 32'd1 : quo_q;

  // Divider sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDiv;
      StDiv:   if (iter_q == 5'd31) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output counter and pending-count handoff
  always_comb begin
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    half_act_d   = half_act_q;
    half_pend_d  = half_pend_q;
    pend_valid_d = pend_valid_q;
    if (stop) begin
      clk_out_d    = 1'b0;
      cnt_d        = 32'd0;
      half_act_d   = 32'd0;
      pend_valid_d = 1'b0;
    end else if (half_act_q != 32'd0) begin
      if (cnt_q == half_act_q - 32'd1) begin
        clk_out_d = ~clk_out_q;
        cnt_d     = 32'd0;
        if (pend_valid_q) begin
          half_act_d   = half_pend_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (pend_valid_q) begin
      half_act_d   = half_pend_q;
      cnt_d        = 32'd0;
      pend_valid_d = 1'b0;
    end
    // Completion cannot coincide with stop (stop needs an idle divider).
    if (state_q == StDone) begin
      half_pend_d  = half_new;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      freq_lat_q   <= 27'd0;
      iter_q       <= 5'd0;
      quo_q        <= 32'd0;
      rem_q        <= 28'd0;
      half_act_q   <= 32'd0;
      half_pend_q  <= 32'd0;
      pend_valid_q <= 1'b0;
      cnt_q        <= 32'd0;
      clk_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_act_q   <= half_act_d;
      half_pend_q  <= half_pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      if (freq_change) freq_lat_q <= freq;
      if (start) begin
        iter_q <= 5'd0;
        rem_q  <= 28'd0;
        quo_q  <= CLK_HZ;
      end else if (state_q == StDiv) begin
        iter_q <= iter_q + 5'd1;
        rem_q  <= ge ? diff : trial[27:0];
        quo_q  <= {quo_q[30:0], ge};
      end
    end
  end

  assign clk_out = clk_out_q;

`ifdef CLOCK_DIVIDER_LOCKED_EN
  logic locked_q, locked_d;
  logic load;

  // Same condition under which the counter block takes half_pend into half_act.
  assign load = !stop && pend_valid_q &&
                ((half_act_q == 32'd0) || (cnt_q == half_act_q - 32'd1));

  always_comb begin
    locked_d = locked_q;
    if (freq_change || (freq_lat_q == 27'd0)) begin
      locked_d = 1'b0;
    end else if (load && (freq_lat_q == freq) && !busy) begin
      locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) locked_q <= 1'b0;
    else       locked_q <= locked_d;
  end

  assign locked = locked_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at CLK_HZ = 100 MHz. Expected values are
// hand-computed half-period counts and edge numbers from the reset release.

module tb_clock_divider;

  logic        clk;
  logic        reset;
  logic [26:0] freq;
  logic        clk_out;
`ifdef CLOCK_DIVIDER_LOCKED_EN
  logic        locked;
`endif

  int errors = 0;
  int checks = 0;

  clock_divider #(.CLK_HZ(100_000_000)) dut (
    .clk     (clk),
    .reset   (reset),
    .freq    (freq),
`ifdef CLOCK_DIVIDER_LOCKED_EN
    .locked  (locked),
`endif
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Length in clk cycles of the next complete clk_out phase; -1 on timeout.
  task automatic phase_len(input int budget, output int len);
    logic v;
    int   n;
    v = clk_out;
    n = 0;
    while (clk_out === v && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      len = -1;
    end else begin
      v   = clk_out;
      len = 0;
      do begin
        tick(1);
        len++;
      end while (clk_out === v && len < budget);
      if (clk_out === v) len = -1;
    end
  endtask

  task automatic wait_high(input int budget);
    int n;
    n = 0;
    while (clk_out !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_high", {31'd0, clk_out}, 32'd1);
  endtask

  initial begin
    int   len;
    logic v;

    reset = 1'b1;
    freq  = 27'd25_000_000;
    #50;
    chk("reset_clk_out", {31'd0, clk_out}, 32'd0);
`ifdef CLOCK_DIVIDER_LOCKED_EN
    chk("reset_locked", {31'd0, locked}, 32'd0);
`endif
    #50 reset = 1'b0;

    // 25 MHz -> half=2, first rise on edge 37, period 4.
    tick(1);            // edge 1
    tick(35);           // edge 36
    chk("f25m_e36", {31'd0, clk_out}, 32'd0);
`ifdef CLOCK_DIVIDER_LOCKED_EN
    chk("f25m_locked", {31'd0, locked}, 32'd1);
`endif
    tick(1); chk("f25m_e37", {31'd0, clk_out}, 32'd1);
    tick(1); chk("f25m_e38", {31'd0, clk_out}, 32'd1);
    tick(1); chk("f25m_e39", {31'd0, clk_out}, 32'd0);
    tick(1); chk("f25m_e40", {31'd0, clk_out}, 32'd0);
    tick(1); chk("f25m_e41", {31'd0, clk_out}, 32'd1);

    // 60 MHz -> quotient 0, clamped to half=1: toggle every cycle.
    freq = 27'd60_000_000;
    tick(40);
    for (int i = 0; i < 4; i++) begin
      v = clk_out;
      tick(1);
      chk("f60m_toggle", {31'd0, clk_out}, {31'd0, ~v});
    end

    // Maximum freq -> half=1 as well.
    freq = 27'd134_217_727;
`ifdef CLOCK_DIVIDER_LOCKED_EN
    tick(1);
    chk("fmax_unlock", {31'd0, locked}, 32'd0);
    tick(39);
    chk("fmax_locked", {31'd0, locked}, 32'd1);
`else
    tick(40);
`endif
    for (int i = 0; i < 2; i++) begin
      v = clk_out;
      tick(1);
      chk("fmax_toggle", {31'd0, clk_out}, {31'd0, ~v});
    end

    // 10 MHz -> half=5.
    freq = 27'd10_000_000;
    tick(40);
    phase_len(100, len); chk("f10m_phase", len, 32'd5);
    phase_len(100, len); chk("f10m_phase", len, 32'd5);

    // Change to 5 MHz mid-phase: no phase shorter than 5, then settle at 10.
    tick(2);
    freq = 27'd5_000_000;
    for (int i = 0; i < 4; i++) begin
      phase_len(100, len);
      chk("f5m_min_phase", {31'd0, (len >= 5)}, 32'd1);
    end
    tick(30);
    phase_len(100, len); chk("f5m_phase", len, 32'd10);
    phase_len(100, len); chk("f5m_phase", len, 32'd10);

    // freq=0 while high -> low on the next edge and stays low.
    wait_high(40);
    freq = 27'd0;
    tick(1);
    chk("stop_low", {31'd0, clk_out}, 32'd0);
`ifdef CLOCK_DIVIDER_LOCKED_EN
    chk("stop_locked", {31'd0, locked}, 32'd0);
`endif
    tick(50);
    chk("stop_hold", {31'd0, clk_out}, 32'd0);

    // Restart at 50 MHz (half=1): first rise 36 edges after the change.
    freq = 27'd50_000_000;
    tick(35);
    chk("f50m_e35", {31'd0, clk_out}, 32'd0);
    tick(1);
    chk("f50m_e36", {31'd0, clk_out}, 32'd1);
    tick(1);
    chk("f50m_e37", {31'd0, clk_out}, 32'd0);

    // Async reset during a division, while clk_out is high.
    freq = 27'd10_000_000;
    tick(5);
    wait_high(4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clk_out", {31'd0, clk_out}, 32'd0);
`ifdef CLOCK_DIVIDER_LOCKED_EN
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(1);            // edge 1
    tick(35);           // edge 36
`ifdef CLOCK_DIVIDER_LOCKED_EN
    chk("rst_relock", {31'd0, locked}, 32'd1);
`endif
    tick(3);            // edge 39
    chk("rst_f10m_e39", {31'd0, clk_out}, 32'd0);
    tick(1);
    chk("rst_f10m_e40", {31'd0, clk_out}, 32'd1);
    tick(5);
    chk("rst_f10m_e45", {31'd0, clk_out}, 32'd0);

    // 10 Hz from stopped: half=5_000_000 (too long to run to the first rise).
    freq = 27'd0;
    tick(2);
    freq = 27'd10;
    tick(34);
    chk("f10hz_half_pend", dut.half_pend_q, 32'd5_000_000);
    tick(1);
    chk("f10hz_half_act", dut.half_act_q, 32'd5_000_000);
    tick(1000);
    chk("f10hz_low", {31'd0, clk_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
